vdp2_vram_write_drain: RTL and testbench



---
 rtl/vdp2_vram_write_drain.sv | 133 +++++++++++++
 tb/tb_vdp2_vram_write_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vdp2_vram_write_drain.sv
// Drains the VDP2 CPU write FIFO into the VRAM arbiter, one outstanding write at a time.
// Latency: pop to VRAM_REQ is 2 cycles with a free slot; REQ is held until VRAM_ACK. Optional merging: VDP2_WDRAIN_MERGE_EN.
module vdp2_vram_write_drain #(
    parameter int ADDR_W = 18
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [35:0]       FIFO_Q,
    input  logic              FIFO_EMPTY,
    output logic              FIFO_RDREQ,
    input  logic              SLOT_EN,
    output logic              VRAM_REQ,
    output logic [ADDR_W-1:0] VRAM_A,
    output logic [15:0]       VRAM_D,
    output logic [1:0]        VRAM_WE,
    input  logic              VRAM_ACK,
    output logic              WR_DONE,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        WRITE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] ha;
    logic [1:0]        hbe;
    logic [15:0]       hd;

    logic [ADDR_W-1:0] head_a;
    logic [1:0]        head_be;
    logic [15:0]       head_d;
    logic [15:0]       hd_mrg;

    logic              load;
    logic              issue;
    logic              merge;
    logic              done;

    assign head_a  = FIFO_Q[18 +: ADDR_W];
    assign head_be = FIFO_Q[17:16];
    assign head_d  = FIFO_Q[15:0];

    // Byte-wise overlay of the head entry onto the held data.
    assign hd_mrg = {head_be[1] ? head_d[15:8] : hd[15:8],
                     head_be[0] ? head_d[7:0]  : hd[7:0]};

    assign BUSY = (state != IDLE) | ~FIFO_EMPTY;

    always_comb begin
        state_nxt  = state;
        FIFO_RDREQ = 1'b0;
        load       = 1'b0;
        issue      = 1'b0;
        merge      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (!FIFO_EMPTY) begin
                    FIFO_RDREQ = 1'b1;
                    load       = 1'b1;
                    state_nxt  = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (hbe == 2'b00) begin
                    state_nxt = IDLE;
                end else if (SLOT_EN) begin
                    issue     = 1'b1;
                    state_nxt = WRITE;
                end
`ifdef VDP2_WDRAIN_MERGE_EN
                else if (!FIFO_EMPTY && (head_a == ha)) begin
                    FIFO_RDREQ = 1'b1;
                    merge      = 1'b1;
                end
`endif
            end
            WRITE: begin
                if (VRAM_ACK) begin
                    done = 1'b1;
                    // Chain straight into the next entry to avoid an idle bubble.
                    if (!FIFO_EMPTY) begin
                        FIFO_RDREQ = 1'b1;
                        load       = 1'b1;
                        state_nxt  = WAIT_SLOT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            ha       <= '0;
            hbe      <= '0;
            hd       <= '0;
            VRAM_REQ <= 1'b0;
            VRAM_A   <= '0;
            VRAM_D   <= '0;
            VRAM_WE  <= '0;
            WR_DONE  <= 1'b0;
        end else begin
            state   <= state_nxt;
            WR_DONE <= done;
            if (load) begin
                ha  <= head_a;
                hbe <= head_be;
                hd  <= head_d;
            end else if (merge) begin
                hbe <= hbe | head_be;
                hd  <= hd_mrg;
            end
            if (issue) begin
                VRAM_REQ <= 1'b1;
                VRAM_A   <= ha;
                VRAM_D   <= hd;
                VRAM_WE  <= hbe;
            end else if (done) begin
                VRAM_REQ <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdp2_vram_write_drain.sv
// Bench: show-ahead FIFO model and delayed-ack arbiter model around the drain, with a write scoreboard.
module tb_vdp2_vram_write_drain;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [35:0] FIFO_Q;
    logic        FIFO_EMPTY;
    logic        FIFO_RDREQ;
    logic        SLOT_EN;
    logic        VRAM_REQ;
    logic [17:0] VRAM_A;
    logic [15:0] VRAM_D;
    logic [1:0]  VRAM_WE;
    logic        VRAM_ACK;
    logic        WR_DONE;
    logic        BUSY;

    always #5 CLK = ~CLK;

    vdp2_vram_write_drain #(.ADDR_W(18)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .FIFO_Q     (FIFO_Q),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RDREQ (FIFO_RDREQ),
        .SLOT_EN    (SLOT_EN),
        .VRAM_REQ   (VRAM_REQ),
        .VRAM_A     (VRAM_A),
        .VRAM_D     (VRAM_D),
        .VRAM_WE    (VRAM_WE),
        .VRAM_ACK   (VRAM_ACK),
        .WR_DONE    (WR_DONE),
        .BUSY       (BUSY)
    );

    typedef struct {
        logic [17:0] a;
        logic [1:0]  we;
        logic [15:0] d;
    } wr_t;

    logic [35:0] fq[$];
    wr_t         exp_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          ack_delay = 0;
    int          req_age  = 0;
    logic [35:0] snap;
    int          w0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        FIFO_EMPTY = (fq.size() == 0);
        FIFO_Q     = (fq.size() != 0) ? fq[0] : 36'd0;
    endtask

    task automatic push(input logic [17:0] a, input logic [1:0] be, input logic [15:0] d,
                        input bit expect_wr);
        wr_t w;
        fq.push_back({a, be, d});
        if (expect_wr) begin
            w.a = a; w.we = be; w.d = d;
            exp_q.push_back(w);
        end
        refresh_fifo();
    endtask

    task automatic expect_write(input logic [17:0] a, input logic [1:0] we, input logic [15:0] d);
        wr_t w;
        w.a = a; w.we = we; w.d = d;
        exp_q.push_back(w);
    endtask

    // One clock: drive ack, sample pre-edge, advance, update FIFO model, check WR_DONE.
    task automatic tick();
        bit  pop, ack_t, req_pre, rst_pre;
        wr_t w;
        #1;
        VRAM_ACK = (VRAM_REQ === 1'b1) && RST_N && (req_age >= ack_delay);
        #1;
        pop     = (FIFO_RDREQ === 1'b1);
        ack_t   = VRAM_ACK && (VRAM_REQ === 1'b1);
        req_pre = (VRAM_REQ === 1'b1);
        rst_pre = RST_N;
        if (req_pre && rst_pre) begin
            if (req_age == 0) snap = {VRAM_A, VRAM_WE, VRAM_D};
            else check("vram_stable", {VRAM_A, VRAM_WE, VRAM_D}, snap);
        end
        if (ack_t) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {VRAM_A, VRAM_WE, VRAM_D}, 64'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", VRAM_A, w.a);
                check("wr_we", VRAM_WE, w.we);
                check("wr_data", VRAM_D, w.d);
                check("req_len", req_age + 1, ack_delay + 1);
            end
            if (fq.size() != 0) check("rdreq_on_ack", pop, 1);
        end
        @(posedge CLK);
        #1;
        if (pop) void'(fq.pop_front());
        refresh_fifo();
        req_age = (req_pre && !ack_t && rst_pre) ? req_age + 1 : 0;
        check("wr_done", WR_DONE, ack_t && rst_pre);
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int c = 0;
        while ((fq.size() != 0 || BUSY !== 1'b0 || exp_q.size() != 0) && c < max) begin
            tick();
            c++;
        end
        check({tag, "_drained"}, c < max, 1);
        check({tag, "_busy"}, BUSY, 1'b0);
    endtask

    initial begin
        bit any_req;
        int c;
        RST_N    = 1'b0;
        SLOT_EN  = 1'b0;
        VRAM_ACK = 1'b0;
        refresh_fifo();
        repeat (3) tick();
        check("rst_req", VRAM_REQ, 1'b0);
        check("rst_addr", VRAM_A, 18'd0);
        check("rst_data", VRAM_D, 16'd0);
        check("rst_we", VRAM_WE, 2'b00);
        check("rst_rdreq", FIFO_RDREQ, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        RST_N = 1'b1;
        tick();

        // Single write, same-cycle ack
        SLOT_EN = 1'b1; ack_delay = 0; w0 = n_writes;
        push(18'h01234, 2'b11, 16'hBEEF, 1);
        run_until_idle("single", 50);
        check("single_count", n_writes - w0, 1);

        // Slot gating
        SLOT_EN = 1'b0; w0 = n_writes;
        push(18'h00100, 2'b11, 16'h1111, 1);
        tick();
        any_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_req |= (VRAM_REQ !== 1'b0);
        end
        check("gate_no_req", any_req, 0);
        SLOT_EN = 1'b1;
        tick();
        check("gate_req", VRAM_REQ, 1'b1);
        run_until_idle("gate", 50);
        check("gate_count", n_writes - w0, 1);

        // Ack stall, back-to-back
        ack_delay = 3; w0 = n_writes;
        push(18'h00200, 2'b11, 16'hA001, 1);
        push(18'h00201, 2'b01, 16'hB002, 1);
        push(18'h00202, 2'b10, 16'hC003, 1);
        push(18'h00203, 2'b11, 16'hD004, 1);
        run_until_idle("b2b", 100);
        check("b2b_count", n_writes - w0, 4);

        // Null entry dropped
        ack_delay = 0; w0 = n_writes;
        push(18'h00009, 2'b00, 16'h1234, 0);
        push(18'h00005, 2'b01, 16'h0042, 1);
        run_until_idle("null", 50);
        check("null_count", n_writes - w0, 1);

        // Same-address entries while no slot is available
        SLOT_EN = 1'b0; w0 = n_writes;
`ifdef VDP2_WDRAIN_MERGE_EN
        push(18'h00007, 2'b10, 16'hAA00, 0);
        push(18'h00007, 2'b01, 16'h0055, 0);
        expect_write(18'h00007, 2'b11, 16'hAA55);
        repeat (4) tick();
        check("merge_popped", fq.size(), 0);
        SLOT_EN = 1'b1;
        run_until_idle("merge", 50);
        check("merge_count", n_writes - w0, 1);
`else
        push(18'h00007, 2'b10, 16'hAA00, 1);
        push(18'h00007, 2'b01, 16'h0055, 1);
        repeat (4) tick();
        check("nomerge_held", fq.size(), 1);
        SLOT_EN = 1'b1;
        run_until_idle("nomerge", 50);
        check("nomerge_count", n_writes - w0, 2);
`endif

        // Reset while a request is pending
        ack_delay = 1000;
        push(18'h3FFFF, 2'b11, 16'hFFFF, 1);
        c = 0;
        while (VRAM_REQ !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check("mid_req_seen", VRAM_REQ, 1'b1);
        tick();
        RST_N = 1'b0;
        tick();
        exp_q.delete();
        check("mid_rst_req", VRAM_REQ, 1'b0);
        check("mid_rst_addr", VRAM_A, 18'd0);
        check("mid_rst_data", VRAM_D, 16'd0);
        check("mid_rst_we", VRAM_WE, 2'b00);
        check("mid_rst_done", WR_DONE, 1'b0);
        check("mid_rst_busy", BUSY, 1'b0);
        RST_N = 1'b1; ack_delay = 0;
        tick();

        // Recovery after reset
        w0 = n_writes;
        push(18'h2AAAA, 2'b01, 16'h5A5A, 1);
        run_until_idle("recover", 50);
        check("recover_count", n_writes - w0, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
